// File: rtl/vrf_write_arbiter.sv
// vrf_write_arbiter: round-robin arbiter that shares one lane VRF write port
// between NUM_REQ requesters. These are the stage-3 write queue, the cross-lane
// write, the mask-unit write-back and the load/store write-back.
//
// The winner's payload is captured into a single output register. That
// register can be popped and refilled in the same cycle, so the port sustains
// one write per cycle. A request appears on the VRF side one cycle after its
// transfer.
//
// Optional feature (compile-time macro VRF_WRITE_ARB_LAST_LOCK_EN):
//   A transfer with last==0 locks arbitration onto that requester. The lock
//   holds until that requester transfers with last==1. Without the macro,
//   req_last is plain payload and arbitration is pure round-robin.
//
// Ports:
//   clock, reset              clock; synchronous active-low reset
//   req_valid / req_ready     per-requester handshake (ready is combinational,
//                             one-hot or zero)
//   req_vd, req_offset,       packed per-requester payload; requester i
//   req_mask, req_data,       occupies slice [W*i +: W] of each bus
//   req_last,
//   req_instructionIndex
//   vrfWriteRequest_*         registered write request towards the VRF
//   grant_id                  requester whose payload sits in the output register
module vrf_write_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [5*NUM_REQ-1:0]    req_vd,
    input  logic [5*NUM_REQ-1:0]    req_offset,
    input  logic [4*NUM_REQ-1:0]    req_mask,
    input  logic [32*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    input  logic [3*NUM_REQ-1:0]    req_instructionIndex,
    input  logic                    vrfWriteRequest_ready,
    output logic                    vrfWriteRequest_valid,
    output logic [4:0]              vrfWriteRequest_bits_vd,
    output logic [4:0]              vrfWriteRequest_bits_offset,
    output logic [3:0]              vrfWriteRequest_bits_mask,
    output logic [31:0]             vrfWriteRequest_bits_data,
    output logic                    vrfWriteRequest_bits_last,
    output logic [2:0]              vrfWriteRequest_bits_instructionIndex,
    output logic [IDX_W-1:0]        grant_id
);

    localparam int unsigned VD_W   = 5;
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IIDX_W = 3;
    localparam int unsigned SUM_W  = IDX_W + 1;

    logic [IDX_W-1:0]  ptr;
    logic              loadEn_c;
    logic              any_c;
    logic [IDX_W-1:0]  rrWinner_c;
    logic              rrFound_c;
    logic [SUM_W-1:0]  scanIdx_c;
    logic [IDX_W-1:0]  selId_c;
    logic [IDX_W-1:0]  nextPtr_c;

    logic [VD_W-1:0]   selVd_c;
    logic [OFF_W-1:0]  selOffset_c;
    logic [MASK_W-1:0] selMask_c;
    logic [DATA_W-1:0] selData_c;
    logic              selLast_c;
    logic [IIDX_W-1:0] selIidx_c;

    // Output slot can take a new write when empty or being popped this cycle.
    assign loadEn_c = ~vrfWriteRequest_valid | vrfWriteRequest_ready;

    // Round-robin scan starting at ptr. The wrap is explicit so that a
    // NUM_REQ that is not a power of two still cycles through 0..NUM_REQ-1.
    always_comb begin
        rrWinner_c = '0;
        rrFound_c  = 1'b0;
        scanIdx_c  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx_c = SUM_W'(ptr) + SUM_W'(k);
            if (scanIdx_c >= SUM_W'(NUM_REQ)) begin
                scanIdx_c = scanIdx_c - SUM_W'(NUM_REQ);
            end
            if (!rrFound_c && req_valid[scanIdx_c[IDX_W-1:0]]) begin
                rrWinner_c = scanIdx_c[IDX_W-1:0];
                rrFound_c  = 1'b1;
            end
        end
    end

`ifdef VRF_WRITE_ARB_LAST_LOCK_EN
    logic             lockValid;
    logic [IDX_W-1:0] lockId;

    // A held lock pins the grant even while the owner is idle; others wait.
    always_comb begin
        if (lockValid) begin
            selId_c = lockId;
            any_c   = req_valid[lockId];
        end else begin
            selId_c = rrWinner_c;
            any_c   = |req_valid;
        end
    end

    // A transfer with last==0 opens or extends the lock. last==1 from the owner releases it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lockValid <= 1'b0;
            lockId    <= '0;
        end else if (loadEn_c && any_c) begin
            lockValid <= ~selLast_c;
            lockId    <= selId_c;
        end
    end
`else
    always_comb begin
        selId_c = rrWinner_c;
        any_c   = |req_valid;
    end
`endif

    // Only the winner sees ready, and only when the slot is free.
    always_comb begin
        req_ready = '0;
        if (reset && loadEn_c && any_c) begin
            req_ready[selId_c] = 1'b1;
        end
    end

    // Payload mux of the selected requester.
    always_comb begin
        selVd_c     = '0;
        selOffset_c = '0;
        selMask_c   = '0;
        selData_c   = '0;
        selLast_c   = 1'b0;
        selIidx_c   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (selId_c == IDX_W'(i)) begin
                selVd_c     = req_vd[VD_W*i +: VD_W];
                selOffset_c = req_offset[OFF_W*i +: OFF_W];
                selMask_c   = req_mask[MASK_W*i +: MASK_W];
                selData_c   = req_data[DATA_W*i +: DATA_W];
                selLast_c   = req_last[i];
                selIidx_c   = req_instructionIndex[IIDX_W*i +: IIDX_W];
            end
        end
    end

    assign nextPtr_c = (selId_c == IDX_W'(NUM_REQ - 1)) ? '0 : selId_c + IDX_W'(1);

    // Output register and round-robin pointer. The pointer advances only on a transfer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vrfWriteRequest_valid                 <= 1'b0;
            vrfWriteRequest_bits_vd               <= '0;
            vrfWriteRequest_bits_offset           <= '0;
            vrfWriteRequest_bits_mask             <= '0;
            vrfWriteRequest_bits_data             <= '0;
            vrfWriteRequest_bits_last             <= 1'b0;
            vrfWriteRequest_bits_instructionIndex <= '0;
            grant_id                              <= '0;
            ptr                                   <= '0;
        end else if (loadEn_c) begin
            if (any_c) begin
                vrfWriteRequest_valid                 <= 1'b1;
                vrfWriteRequest_bits_vd               <= selVd_c;
                vrfWriteRequest_bits_offset           <= selOffset_c;
                vrfWriteRequest_bits_mask             <= selMask_c;
                vrfWriteRequest_bits_data             <= selData_c;
                vrfWriteRequest_bits_last             <= selLast_c;
                vrfWriteRequest_bits_instructionIndex <= selIidx_c;
                grant_id                              <= selId_c;
                ptr                                   <= nextPtr_c;
            end else begin
                vrfWriteRequest_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Bench for vrf_write_arbiter: a per-cycle reference model plus directed scenarios
// with literal expectations.
module tb_vrf_write_arbiter;

    localparam int N = 4;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [5*N-1:0]    req_vd;
    logic [5*N-1:0]    req_offset;
    logic [4*N-1:0]    req_mask;
    logic [32*N-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [3*N-1:0]    req_instructionIndex;
    logic              sinkReady;
    logic              outValid;
    logic [4:0]        outVd;
    logic [4:0]        outOffset;
    logic [3:0]        outMask;
    logic [31:0]       outData;
    logic              outLast;
    logic [2:0]        outIidx;
    logic [1:0]        grantId;

    vrf_write_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
        .clock                                 (clock),
        .reset                                 (reset),
        .req_valid                             (req_valid),
        .req_ready                             (req_ready),
        .req_vd                                (req_vd),
        .req_offset                            (req_offset),
        .req_mask                              (req_mask),
        .req_data                              (req_data),
        .req_last                              (req_last),
        .req_instructionIndex                  (req_instructionIndex),
        .vrfWriteRequest_ready                 (sinkReady),
        .vrfWriteRequest_valid                 (outValid),
        .vrfWriteRequest_bits_vd               (outVd),
        .vrfWriteRequest_bits_offset           (outOffset),
        .vrfWriteRequest_bits_mask             (outMask),
        .vrfWriteRequest_bits_data             (outData),
        .vrfWriteRequest_bits_last             (outLast),
        .vrfWriteRequest_bits_instructionIndex (outIidx),
        .grant_id                              (grantId)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Per-requester payload as seen by the bench.
    logic [4:0]  rVd     [N];
    logic [4:0]  rOffset [N];
    logic [3:0]  rMask   [N];
    logic [31:0] rData   [N];
    logic        rLast   [N];
    logic [2:0]  rIidx   [N];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expd);
        checks++;
        if (act !== expd) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expd, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_vd[5*i +: 5]               = rVd[i];
            req_offset[5*i +: 5]           = rOffset[i];
            req_mask[4*i +: 4]             = rMask[i];
            req_data[32*i +: 32]           = rData[i];
            req_last[i]                    = rLast[i];
            req_instructionIndex[3*i +: 3] = rIidx[i];
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit          mValid;
    int          mPtr;
    int          mGrant;
    logic [4:0]  mVd;
    logic [4:0]  mOffset;
    logic [3:0]  mMask;
    logic [31:0] mData;
    logic        mLast;
    logic [2:0]  mIidx;
`ifdef VRF_WRITE_ARB_LAST_LOCK_EN
    bit          mLockV;
    int          mLockId;
`endif

    // Requester that would win this cycle, or -1 if none.
    function automatic int modelWinner();
`ifdef VRF_WRITE_ARB_LAST_LOCK_EN
        if (mLockV) return req_valid[mLockId] ? mLockId : -1;
`endif
        for (int k = 0; k < N; k++) begin
            if (req_valid[(mPtr + k) % N]) return (mPtr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        int w;
        w = modelWinner();
        if (!reset) begin
            mValid = 1'b0; mPtr = 0; mGrant = 0;
            mVd = '0; mOffset = '0; mMask = '0; mData = '0; mLast = 1'b0; mIidx = '0;
`ifdef VRF_WRITE_ARB_LAST_LOCK_EN
            mLockV = 1'b0; mLockId = 0;
`endif
        end else if (!mValid || sinkReady) begin
            if (w >= 0) begin
                mValid = 1'b1; mGrant = w;
                mVd = rVd[w]; mOffset = rOffset[w]; mMask = rMask[w];
                mData = rData[w]; mLast = rLast[w]; mIidx = rIidx[w];
                mPtr = (w + 1) % N;
`ifdef VRF_WRITE_ARB_LAST_LOCK_EN
                if (mLockV) mLockV = !rLast[w];
                else if (!rLast[w]) begin mLockV = 1'b1; mLockId = w; end
`endif
            end else begin
                mValid = 1'b0;
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clock) begin
        int w;
        logic [N-1:0] expReady;
        w = modelWinner();
        expReady = '0;
        if (reset === 1'b1 && (!mValid || sinkReady) && w >= 0) expReady[w] = 1'b1;
        chk("model_req_ready", 64'(req_ready), 64'(expReady));
        chk("model_valid", 64'(outValid), 64'(mValid));
        if (mValid) begin
            chk("model_grant_id", 64'(grantId), 64'(mGrant));
            chk("model_payload", {21'd0, outVd, outOffset, outMask, outData, outLast, outIidx},
                {21'd0, mVd, mOffset, mMask, mData, mLast, mIidx});
        end
    end

    // ---------------- directed stimulus ----------------
    bit [N-1:0] tValid [12] = '{4'b1111, 4'b0110, 4'b0000, 4'b1001, 4'b0001, 4'b1111,
                                4'b1100, 4'b0011, 4'b1010, 4'b0101, 4'b1111, 4'b0000};
    bit         tReady [12] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};

    initial begin
        for (int i = 0; i < N; i++) begin
            rVd[i]     = 5'(3 * i + 1);
            rOffset[i] = 5'(i + 8);
            rMask[i]   = 4'(i + 1);
            rData[i]   = 32'h1111_0000 + 32'(i);
            rLast[i]   = 1'b1;
            rIidx[i]   = 3'(i);
        end
        req_valid = '1;
        sinkReady = 1'b1;
        reset     = 1'b0;
        drive();

        // Reset held with everyone valid.
        repeat (2) cyc();
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(outValid), 64'd0);
        chk("rst_grant", 64'(grantId), 64'd0);
        chk("rst_data", 64'(outData), 64'd0);

        reset = 1'b1;
        #1;
        chk("first_ready", 64'(req_ready), 64'b0001);
        cyc();
        chk("first_valid", 64'(outValid), 64'd1);
        chk("first_grant", 64'(grantId), 64'd0);
        chk("first_data", 64'(outData), 64'h1111_0000);

        // Continuous round-robin, no bubbles.
        for (int g = 1; g < 6; g++) begin
            cyc();
            chk("rr_grant", 64'(grantId), 64'(g % 4));
            chk("rr_valid", 64'(outValid), 64'd1);
        end

        // ptr is now 2; only requesters 1 and 3 request.
        req_valid  = 4'b1010;
        rVd[3]     = 5'h0A;
        rOffset[3] = 5'h1F;
        rData[3]   = 32'hDEADBEEF;
        drive();
        cyc();
        chk("sparse_grant3", 64'(grantId), 64'd3);
        chk("sparse_vd", 64'(outVd), 64'h0A);
        chk("sparse_offset", 64'(outOffset), 64'h1F);
        chk("sparse_data", 64'(outData), 64'hDEADBEEF);
        cyc();
        chk("sparse_grant1", 64'(grantId), 64'd1);

        // Stall for 5 cycles.
        sinkReady = 1'b0;
        #1;
        chk("stall_ready0", 64'(req_ready), 64'd0);
        for (int s = 0; s < 5; s++) begin
            cyc();
            chk("stall_grant", 64'(grantId), 64'd1);
            chk("stall_valid", 64'(outValid), 64'd1);
            chk("stall_data", 64'(outData), 64'(rData[1]));
            chk("stall_ready", 64'(req_ready), 64'd0);
        end
        sinkReady = 1'b1;
        #1;
        chk("unstall_ready", 64'(req_ready), 64'b1000);
        cyc();
        chk("unstall_grant", 64'(grantId), 64'd3);

        // Grant 1 so ptr=2, then reset in the middle of a stall.
        req_valid = 4'b0010;
        cyc();
        chk("pre_rst_grant", 64'(grantId), 64'd1);
        req_valid = 4'b1010;
        sinkReady = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("midrst_valid", 64'(outValid), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        reset     = 1'b1;
        sinkReady = 1'b1;
        #1;
        chk("midrst_ptr0", 64'(req_ready), 64'b0010);
        req_valid = 4'b0100;
        rData[2]  = 32'hCAFE_0002;
        drive();
        #1;
        chk("fresh_ready", 64'(req_ready), 64'b0100);
        cyc();
        chk("fresh_grant", 64'(grantId), 64'd2);
        chk("fresh_data", 64'(outData), 64'hCAFE_0002);

        // Drain without refill.
        req_valid = '0;
        cyc();
        chk("drain_valid", 64'(outValid), 64'd0);

        // Mixed valid/ready vectors, checked by the model.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) rData[i] = 32'hA000_0000 + 32'(t * 16 + i);
            drive();
            req_valid = tValid[t];
            sinkReady = tReady[t];
            cyc();
        end

`ifdef VRF_WRITE_ARB_LAST_LOCK_EN
        // Requester 1 sends last=0,0,1 while requester 0 stays valid.
        reset = 1'b0;
        cyc();
        reset     = 1'b1;
        sinkReady = 1'b1;
        req_valid = 4'b0010;
        rLast[1]  = 1'b0;
        drive();
        cyc();
        chk("lock_grant_a", 64'(grantId), 64'd1);
        req_valid = 4'b0011;
        cyc();
        chk("lock_grant_b", 64'(grantId), 64'd1);
        rLast[1] = 1'b1;
        drive();
        cyc();
        chk("lock_grant_c", 64'(grantId), 64'd1);
        cyc();
        chk("lock_release", 64'(grantId), 64'd0);
        req_valid = '0;
        cyc();
`endif

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vrf_write_arbiter.md
Name: vrf_write_arbiter

Overview:
- Shares one lane VRF write port between NUM_REQ requesters: stage-3 write queue, cross-lane write, mask-unit write-back, and load/store write-back.
- Grants round-robin into a single full-throughput output register that drives the VRF write request interface.
- Sits between the lane stage-3 queues and the VRF write port.
- Handshakes are valid/ready on both sides.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of grant index; must equal ceil(log2(NUM_REQ)).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low (0 = reset).
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready; at most one bit high per cycle.
- req_vd  in  5*NUM_REQ  packed vd; requester i occupies bits [5i+4:5i].
- req_offset  in  5*NUM_REQ  packed offset.
- req_mask  in  4*NUM_REQ  packed byte mask.
- req_data  in  32*NUM_REQ  packed data.
- req_last  in  NUM_REQ  packed last flag.
- req_instructionIndex  in  3*NUM_REQ  packed instruction index.
- vrfWriteRequest_ready  in  1  VRF accepts the write.
- vrfWriteRequest_valid  out  1  registered write valid.
- vrfWriteRequest_bits_vd  out  5  registered vd.
- vrfWriteRequest_bits_offset  out  5  registered offset.
- vrfWriteRequest_bits_mask  out  4  registered mask.
- vrfWriteRequest_bits_data  out  32  registered data.
- vrfWriteRequest_bits_last  out  1  registered last.
- vrfWriteRequest_bits_instructionIndex  out  3  registered instruction index.
- grant_id  out  IDX_W  index of the requester whose payload is in the output register.

Behaviour:
- Reset state (reset==0 at a clock edge):
  - vrfWriteRequest_valid=0.
  - All payload registers and grant_id = 0.
  - RR pointer ptr = 0.
  - req_ready is combinational and reads 0 while reset==0.
- Slot free: load_en = ~vrfWriteRequest_valid | vrfWriteRequest_ready.
- Winner selection:
  - Winner w = first i with req_valid[i] in the order ptr, ptr+1, … wrapping modulo NUM_REQ.
  - any = |req_valid.
- Ready:
  - req_ready[i] = load_en & any & (i==w).
  - req_ready is combinational from req_valid and vrfWriteRequest_ready; there is no ready-to-ready dependency across requesters.
- Transfer on requester i: req_valid[i] & req_ready[i]. On the next edge:
  - The output registers capture requester i's payload.
  - grant_id <= i.
  - vrfWriteRequest_valid <= 1.
  - ptr <= (i+1) mod NUM_REQ. When NUM_REQ is not a power of two, ptr wraps at NUM_REQ-1 -> 0.
- Drain without refill: when load_en & ~any, vrfWriteRequest_valid <= 0. Payload registers hold their values (don't-care).
- Stall: when vrfWriteRequest_valid & ~vrfWriteRequest_ready:
  - All output registers hold.
  - req_ready = 0.
  - ptr holds.
- Throughput and latency:
  - Back-to-back pop plus refill in the same cycle is allowed, giving 1 write/cycle sustained.
  - Latency is 1 cycle from request transfer to vrfWriteRequest_valid.
- Fairness:
  - A continuously-valid requester is granted within NUM_REQ transfers.
  - ptr moves only on a transfer.
- Payload is passed unmodified. There is no vd/offset arithmetic.
- A requester dropping valid without a transfer is legal; it is ignored.
- Reset asserted mid-stall discards the held write. No partial state survives.

Optional Feature:
- Macro: VRF_WRITE_ARB_LAST_LOCK_EN.
- With the macro defined:
  - A lock register is added (lock_valid, lock_id).
  - A transfer with req_last==0 sets lock_valid=1 and lock_id=i.
  - While locked, w is forced to lock_id. Other requesters see ready=0 even when lock_id is not valid.
  - A transfer from lock_id with last==1 clears the lock.
  - ptr updates normally on each transfer.
  - lock_valid resets to 0.
- Without the macro:
  - There is no lock state.
  - req_last is payload only.
  - Pure round-robin arbitration.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles with all req_valid=1 -> req_ready=0 and vrfWriteRequest_valid=0. Release reset -> first grant to requester 0, and valid is seen the next cycle with requester 0's payload.
- All 4 requesters valid continuously, sink ready=1 -> grant_id sequence 0,1,2,3,0,…, one write per cycle, no bubbles.
- Only requesters 1 and 3 valid, ptr=2 -> grant 3 then 1. Each payload (e.g. vd=5'h0A, offset=5'h1F, data=32'hDEADBEEF) appears unchanged on the output.
- Sink ready=0 for 5 cycles with the output valid -> all output bits stable, all req_ready=0, ptr unchanged. On ready=1 the same cycle accepts the next winner.
- Reset driven low during a stall -> valid=0 on the next edge and ptr=0. After reset release, requester 2 alone is granted with fresh data.
- (VRF_WRITE_ARB_LAST_LOCK_EN) Requester 1 sends last=0,0,1 while requester 0 is valid throughout -> three consecutive grants to 1, then requester 0 is granted.
